// File: rtl/pipe_stage_buf.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage_buf
// Desc     : Valid/ready pipeline stage register with synchronous flush to a
//            bubble payload. Define PIPE_STAGE_BUF_SKID_EN for a two-entry
//            skid buffer with registered s_ready_o.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_stage_buf #(
  parameter int unsigned      WIDTH       = 32,
  parameter logic [WIDTH-1:0] RST_PAYLOAD = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             s_valid_i,
  output logic             s_ready_o,
  input  logic [WIDTH-1:0] s_data_i,
  output logic             m_valid_o,
  input  logic             m_ready_i,
  output logic [WIDTH-1:0] m_data_o
);

  logic             w_push;
  logic             w_pop;
  logic [WIDTH-1:0] r_main;
  logic [WIDTH-1:0] w_main_nxt;

  assign w_push   = s_valid_i && s_ready_o;
  assign w_pop    = m_valid_o && m_ready_i;
  assign m_data_o = r_main;

`ifdef PIPE_STAGE_BUF_SKID_EN

  localparam logic [1:0] S_EMPTY = 2'b00;
  localparam logic [1:0] S_ONE   = 2'b01;
  localparam logic [1:0] S_TWO   = 2'b10;

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [WIDTH-1:0] r_skid;
  logic [WIDTH-1:0] w_skid_nxt;
  logic             r_ready;

  // Skid only ever fills from ONE when downstream stalls; main is the sole output.
  always_comb begin
    w_state_nxt = r_state;
    w_main_nxt  = r_main;
    w_skid_nxt  = r_skid;
    if (flush_i) begin
      w_state_nxt = S_EMPTY;
      w_main_nxt  = RST_PAYLOAD;
      w_skid_nxt  = RST_PAYLOAD;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_push) begin
            w_main_nxt  = s_data_i;
            w_state_nxt = S_ONE;
          end
        end
        S_ONE: begin
          if (w_push && w_pop) begin
            w_main_nxt = s_data_i;
          end else if (w_pop) begin
            w_state_nxt = S_EMPTY;
          end else if (w_push) begin
            w_skid_nxt  = s_data_i;
            w_state_nxt = S_TWO;
          end
        end
        S_TWO: begin
          if (w_pop) begin
            w_main_nxt  = r_skid;
            w_state_nxt = S_ONE;
          end
        end
        default: begin
          w_state_nxt = S_EMPTY;
          w_main_nxt  = RST_PAYLOAD;
          w_skid_nxt  = RST_PAYLOAD;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_EMPTY;
      r_main  <= RST_PAYLOAD;
      r_skid  <= RST_PAYLOAD;
      r_ready <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_main  <= w_main_nxt;
      r_skid  <= w_skid_nxt;
      r_ready <= (w_state_nxt != S_TWO);
    end
  end

  assign s_ready_o = r_ready;
  assign m_valid_o = (r_state != S_EMPTY);

`else

  localparam logic [0:0] S_EMPTY = 1'b0;
  localparam logic [0:0] S_FULL  = 1'b1;

  logic [0:0] r_state;
  logic [0:0] w_state_nxt;

  // A pop without a push empties the stage but leaves the last payload visible.
  always_comb begin
    w_state_nxt = r_state;
    w_main_nxt  = r_main;
    if (flush_i) begin
      w_state_nxt = S_EMPTY;
      w_main_nxt  = RST_PAYLOAD;
    end else if (w_push) begin
      w_state_nxt = S_FULL;
      w_main_nxt  = s_data_i;
    end else if (w_pop) begin
      w_state_nxt = S_EMPTY;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_EMPTY;
      r_main  <= RST_PAYLOAD;
    end else begin
      r_state <= w_state_nxt;
      r_main  <= w_main_nxt;
    end
  end

  assign s_ready_o = m_ready_i || !m_valid_o;
  assign m_valid_o = (r_state == S_FULL);

`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_buf.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_stage_buf
// Desc     : Scoreboard bench for pipe_stage_buf (both skid build options).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_buf;

  localparam int unsigned  W       = 32;
  localparam logic [W-1:0] RST_VAL = 32'hDEAD_0013;
`ifdef PIPE_STAGE_BUF_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         flush_i;
  logic         s_valid_i;
  logic         s_ready_o;
  logic [W-1:0] s_data_i;
  logic         m_valid_o;
  logic         m_ready_i;
  logic [W-1:0] m_data_o;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] sb[$];
  logic [W-1:0] popped[$];

  always #5 clk = ~clk;

  pipe_stage_buf #(
    .WIDTH       (W),
    .RST_PAYLOAD (RST_VAL)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush_i   (flush_i),
    .s_valid_i (s_valid_i),
    .s_ready_o (s_ready_o),
    .s_data_i  (s_data_i),
    .m_valid_o (m_valid_o),
    .m_ready_i (m_ready_i),
    .m_data_o  (m_data_o)
  );

  // One clock: handshakes are sampled on the falling edge, then inputs may change at posedge+1.
  task automatic tick();
    logic [W-1:0] exp_d;
    @(negedge clk);
    if (rst) begin
      sb.delete();
    end else begin
      if (m_valid_o && m_ready_i) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL sb_unexpected_beat: got %h, required no beat", m_data_o);
        end else begin
          exp_d = sb.pop_front();
          if (m_data_o !== exp_d) begin
            n_fail++;
            $display("FAIL sb_order: got %h, required %h", m_data_o, exp_d);
          end
        end
        popped.push_back(m_data_o);
      end
      if (flush_i) sb.delete();
      else if (s_valid_i && s_ready_o) sb.push_back(s_data_i);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    tick();
    tick();
    n_checks++;
    if (m_valid_o !== 1'b0 || m_data_o !== RST_VAL || s_ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_state: got v=%b d=%h r=%b, required v=0 d=%h r=1",
               m_valid_o, m_data_o, s_ready_o, RST_VAL);
    end
    rst = 1'b0;
    s_valid_i = 1'b1;
    s_data_i  = 32'h99;
    tick();
    s_valid_i = 1'b0;
    n_checks++;
    if (m_valid_o !== 1'b1 || m_data_o !== 32'h99) begin
      n_fail++;
      $display("FAIL first_edge_accept: got v=%b d=%h, required v=1 d=00000099", m_valid_o, m_data_o);
    end
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (m_valid_o !== 1'b0 || m_data_o !== RST_VAL || s_ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL async_reset: got v=%b d=%h r=%b, required v=0 d=%h r=1",
               m_valid_o, m_data_o, s_ready_o, RST_VAL);
    end
    sb.delete();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_streaming();
    logic [W-1:0] beats[3];
    beats = '{32'h11, 32'h22, 32'h33};
    popped.delete();
    m_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      s_valid_i = 1'b1;
      s_data_i  = beats[i];
      #1;
      n_checks++;
      if (s_ready_o !== 1'b1) begin
        n_fail++;
        $display("FAIL stream_ready[%0d]: got %b, required 1", i, s_ready_o);
      end
      tick();
      n_checks++;
      if (m_valid_o !== 1'b1 || m_data_o !== beats[i]) begin
        n_fail++;
        $display("FAIL stream_latency[%0d]: got v=%b d=%h, required v=1 d=%h", i, m_valid_o, m_data_o, beats[i]);
      end
    end
    s_valid_i = 1'b0;
    tick();
    n_checks++;
    if (m_valid_o !== 1'b0 || popped.size() != 3) begin
      n_fail++;
      $display("FAIL stream_drain: got v=%b popped=%0d, required v=0 popped=3", m_valid_o, popped.size());
    end
  endtask

  task automatic test_stall();
    bit a2_done;
    popped.delete();
    m_ready_i = 1'b0;
    s_valid_i = 1'b1;
    s_data_i  = 32'hA1;
    tick();
    s_data_i = 32'hA2;
    #1;
    n_checks++;
    if (s_ready_o !== SKID) begin
      n_fail++;
      $display("FAIL stall_ready_after_a1: got %b, required %b", s_ready_o, SKID);
    end
    a2_done = s_ready_o;
    tick();
    n_checks++;
    if (m_valid_o !== 1'b1 || m_data_o !== 32'hA1 || s_ready_o !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_hold: got v=%b d=%h r=%b, required v=1 d=000000a1 r=0", m_valid_o, m_data_o, s_ready_o);
    end
    tick();
    n_checks++;
    if (m_data_o !== 32'hA1) begin
      n_fail++;
      $display("FAIL stall_stable: got %h, required 000000a1", m_data_o);
    end
    m_ready_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (a2_done && popped.size() >= 2) break;
      s_valid_i = !a2_done;
      s_data_i  = 32'hA2;
      #1;
      if (s_valid_i && s_ready_o) a2_done = 1'b1;
      tick();
    end
    s_valid_i = 1'b0;
    n_checks++;
    if (!a2_done || popped.size() != 2 || popped[0] !== 32'hA1 || popped[1] !== 32'hA2) begin
      n_fail++;
      $display("FAIL stall_order: got accepted=%b count=%0d, required accepted=1 order a1,a2", a2_done, popped.size());
    end
    tick();
    n_checks++;
    if (m_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_empty: got v=%b, required 0", m_valid_o);
    end
  endtask

  task automatic test_flush();
    m_ready_i = 1'b0;
    s_valid_i = 1'b1;
    s_data_i  = 32'h55;
    tick();
    n_checks++;
    if (m_valid_o !== 1'b1 || m_data_o !== 32'h55) begin
      n_fail++;
      $display("FAIL flush_setup: got v=%b d=%h, required v=1 d=00000055", m_valid_o, m_data_o);
    end
    flush_i  = 1'b1;
    s_data_i = 32'h66;
    tick();
    flush_i   = 1'b0;
    s_valid_i = 1'b0;
    n_checks++;
    if (m_valid_o !== 1'b0 || m_data_o !== RST_VAL) begin
      n_fail++;
      $display("FAIL flush_bubble: got v=%b d=%h, required v=0 d=%h", m_valid_o, m_data_o, RST_VAL);
    end
    popped.delete();
    m_ready_i = 1'b1;
    repeat (3) tick();
    n_checks++;
    if (popped.size() != 0 || m_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_dropped: got popped=%0d v=%b, required popped=0 v=0", popped.size(), m_valid_o);
    end
  endtask

  task automatic test_push_pop();
    popped.delete();
    m_ready_i = 1'b1;
    s_valid_i = 1'b1;
    s_data_i  = 32'h70;
    tick();
    s_data_i = 32'h77;
    #1;
    n_checks++;
    if (s_ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL pushpop_ready: got %b, required 1", s_ready_o);
    end
    tick();
    s_valid_i = 1'b0;
    n_checks++;
    if (m_valid_o !== 1'b1 || m_data_o !== 32'h77 || s_ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL pushpop_out: got v=%b d=%h r=%b, required v=1 d=00000077 r=1", m_valid_o, m_data_o, s_ready_o);
    end
    tick();
    n_checks++;
    if (popped.size() != 2 || popped[0] !== 32'h70 || popped[1] !== 32'h77) begin
      n_fail++;
      $display("FAIL pushpop_order: got count=%0d, required 70,77", popped.size());
    end
  endtask

  task automatic test_reset_mid_stall();
    m_ready_i = 1'b0;
    s_valid_i = 1'b1;
    s_data_i  = 32'hB1;
    tick();
    s_data_i = 32'hB2;
    tick();
    s_valid_i = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (m_valid_o !== 1'b0 || m_data_o !== RST_VAL || s_ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL midstall_reset: got v=%b d=%h r=%b, required v=0 d=%h r=1",
               m_valid_o, m_data_o, s_ready_o, RST_VAL);
    end
    sb.delete();
    popped.delete();
    tick();
    rst       = 1'b0;
    m_ready_i = 1'b1;
    s_valid_i = 1'b1;
    s_data_i  = 32'h88;
    tick();
    s_valid_i = 1'b0;
    n_checks++;
    if (m_valid_o !== 1'b1 || m_data_o !== 32'h88) begin
      n_fail++;
      $display("FAIL midstall_restart: got v=%b d=%h, required v=1 d=00000088", m_valid_o, m_data_o);
    end
    tick();
    n_checks++;
    if (m_valid_o !== 1'b0 || popped.size() != 1 || popped[0] !== 32'h88) begin
      n_fail++;
      $display("FAIL midstall_stale: got v=%b popped=%0d, required v=0 popped=1 (88)", m_valid_o, popped.size());
    end
  endtask

  initial begin
    rst       = 1'b1;
    flush_i   = 1'b0;
    s_valid_i = 1'b0;
    s_data_i  = '0;
    m_ready_i = 1'b0;
    test_reset();
    test_streaming();
    test_stall();
    test_flush();
    test_push_pop();
    test_reset_mid_stall();
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_leftover: got %0d pending beats, required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/pipe_stage_buf.md
# pipe_stage_buf

Parametrised pipeline stage register with valid/ready handshake, synchronous flush and an optional two-entry skid buffer. It is the generic successor of the fixed per-field stage registers: one instance carries a packed payload (operands, rd address, instruction, PC, offset) between any two core stages. It adds back-pressure (stall) support and bubble insertion on flush. The bubble value is a NOP-equivalent payload.

## Interface
- `WIDTH`, default 32: payload width in bits; legal values are 1 and above.
- `RST_PAYLOAD`, default `WIDTH'h0`: payload driven after reset and after flush (bubble, e.g. `INST_NOP` in the instruction field).

Ports:
- `clk`  in  1  clock; all state changes on its rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `flush_i`  in  1  synchronous flush; discards all held entries.
- `s_valid_i`  in  1  upstream payload valid.
- `s_ready_o`  out  1  stage can accept; a transfer occurs when `s_valid_i && s_ready_o`.
- `s_data_i`  in  WIDTH  upstream payload.
- `m_valid_o`  out  1  downstream payload valid.
- `m_ready_i`  in  1  downstream accepts; a transfer occurs when `m_valid_o && m_ready_i`.
- `m_data_o`  out  WIDTH  downstream payload, always driven from a register.

## Operation
- Reset (`rst`=1, any time, including mid-transfer):
  - All entries are emptied.
  - `m_valid_o`=0.
  - `m_data_o`=`RST_PAYLOAD`.
  - `s_ready_o`=1.
  - Reset takes effect immediately and does not wait for `clk`.
- Priority each cycle: `rst` > `flush_i` > handshakes.
- Flush (`flush_i`=1 at an edge):
  - All entries become empty.
  - `m_data_o`=`RST_PAYLOAD`.
  - An upstream beat presented in the same cycle is dropped, even if `s_ready_o`=1.
  - A downstream handshake in the same cycle counts as consumed.
- Without skid (macro undefined):
  - The block has one register and two states, EMPTY and FULL.
  - `s_ready_o` = `m_ready_i || !m_valid_o`, combinational.
  - On an upstream transfer, the register loads `s_data_i` and the state is FULL.
  - On a downstream transfer with no upstream transfer, the state becomes EMPTY and `m_data_o` holds its last value.
- With skid (macro defined): the block has a main register, a skid register and three states, EMPTY, ONE and TWO.
  - EMPTY:
    - Accepts into main, then goes to ONE.
  - ONE:
    - Push and pop together: main reloads; stay in ONE.
    - Pop only: go to EMPTY.
    - Push only: incoming beat goes to skid; go to TWO.
  - TWO:
    - `s_ready_o`=0.
    - On pop, skid moves to main; go to ONE.
  - `s_ready_o` is registered: 1 unless the next state is TWO.
  - The skid entry is never visible on `m_data_o` directly.
- Ordering: beats leave in acceptance order; none are duplicated or lost except on flush or reset.
- While `m_valid_o`=1 and `m_ready_i`=0, `m_data_o` is stable.

## Timing
- Latency: a beat accepted at edge N appears on `m_valid_o`/`m_data_o` after edge N.
- Throughput: 1 beat per cycle when `m_ready_i` is held at 1, in both modes.
- Without skid, a `m_ready_i` deassert propagates to `s_ready_o` in the same cycle (combinational path).
- With skid, `s_ready_o` falls one cycle after the stall begins. The extra beat accepted in that cycle is held in skid.
- The first edge after `rst` deasserts may accept a beat.

## Configuration
- `PIPE_STAGE_BUF_SKID_EN`:
  - Defined: two-entry skid buffer with registered `s_ready_o`, which breaks the ready timing path.
  - Undefined: single register with combinational `s_ready_o`; smaller area.
- Externally visible ordering, flush and reset behaviour are identical in both modes; only `s_ready_o` timing and capacity differ.

## Test plan
- Reset value and async reset:
  - Assert `rst` between edges → `m_valid_o`=0 and `m_data_o`=`RST_PAYLOAD` immediately; `s_ready_o`=1.
- Streaming:
  - With `m_ready_i`=1, send 0x11, 0x22, 0x33 on consecutive cycles → they appear on the following consecutive cycles; `s_ready_o` stays 1.
- Stall:
  - Send 0xA1 then 0xA2 with `m_ready_i`=0.
  - Without skid: `s_ready_o` drops after 0xA1.
  - With skid: both beats are accepted, then `s_ready_o`=0.
  - Release the stall → output order is 0xA1, 0xA2 with no loss.
- Flush with input:
  - Stage FULL with 0x55; assert `flush_i` together with `s_valid_i`, data 0x66.
  - Next cycle → `m_valid_o`=0, `m_data_o`=`RST_PAYLOAD`; 0x66 never appears.
- Simultaneous push/pop:
  - In ONE/FULL with `m_ready_i`=1, push 0x77 → next cycle `m_data_o`=0x77, `m_valid_o`=1, no skid use.
- Reset mid-stall:
  - In TWO, assert `rst` → all empty.
  - After release, send 0x88 → it appears after 1 cycle; no stale beats.
